// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU codes and RV64I+Zba decode constants
//
// Purpose: constants shared by the issue-stage decoder, the E-stage registers
//          and the bench.
// Ports:   none (package).

package alu_pkg;

  // ALU operation codes driven on ALUControlE
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SH1ADD = 4'b1000;
  localparam logic [3:0] ALU_SH2ADD = 4'b1001;
  localparam logic [3:0] ALU_SH3ADD = 4'b1010;
  localparam logic [3:0] ALU_ADDUW  = 4'b1011;

  // Major opcodes
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_R32 = 7'b0111011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // funct7 groups
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_ZBA_SH = 7'b0010000;
  localparam logic [6:0] F7_ADDUW  = 7'b0000100;

  // Supported branch conditions
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Basic ALU ops shared by R-type (funct7 0000000) and I-type; legal=0 if
  // funct3 is not one of the five supported operations.
  function automatic logic [4:0] baseOp(input logic [2:0] f3);
    case (f3)
      3'b000:  baseOp = {1'b1, ALU_ADD};
      3'b111:  baseOp = {1'b1, ALU_AND};
      3'b110:  baseOp = {1'b1, ALU_OR};
      3'b010:  baseOp = {1'b1, ALU_SLT};
      3'b100:  baseOp = {1'b1, ALU_XOR};
      default: baseOp = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational D-stage decode for the ALU issue stage
//
// Purpose: map a 32-bit instruction onto ALU control, operand-B select,
//          branch/regwrite flags, illegal flag and sign-extended I immediate.
// Ports:
//   instr       in   32    D-stage instruction word
//   aluControl  out  4     ALU operation (ALU_ADD when illegal)
//   useImm      out  1     operand B comes from the immediate
//   branch      out  1     conditional branch
//   regWrite    out  1     writes a non-x0 destination
//   illegal     out  1     encoding not supported
//   imm         out  XLEN  sign-extended imm[31:20]

module alu_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [3:0]      aluControl,
  output logic            useImm,
  output logic            branch,
  output logic            regWrite,
  output logic            illegal,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] baseDec;
  logic       legal;
  logic       isBranch;
  logic [3:0] op;

  // Source register fields are handled by the E-stage forwarding logic.
  logic       unusedRs;
  assign unusedRs = ^instr[24:15];

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign baseDec = baseOp(funct3);
  assign imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};

  always_comb begin
    legal    = 1'b0;
    isBranch = 1'b0;
    op       = ALU_ADD;
    case (opcode)
      OP_R: begin
        case (funct7)
          F7_BASE: begin
            legal = baseDec[4];
            op    = baseDec[3:0];
          end
          F7_SUB: begin
            legal = (funct3 == 3'b000);
            op    = ALU_SUB;
          end
          F7_ZBA_SH: begin
            case (funct3)
              3'b010:  begin legal = 1'b1; op = ALU_SH1ADD; end
              3'b100:  begin legal = 1'b1; op = ALU_SH2ADD; end
              3'b110:  begin legal = 1'b1; op = ALU_SH3ADD; end
              default: legal = 1'b0;
            endcase
          end
          default: legal = 1'b0;
        endcase
      end
      OP_R32: begin
        legal = (funct7 == F7_ADDUW) && (funct3 == 3'b000);
        op    = ALU_ADDUW;
      end
      OP_I: begin
        legal = baseDec[4];
        op    = baseDec[3:0];
      end
      OP_BR: begin
        legal    = (funct3 == F3_BEQ) || (funct3 == F3_BNE) ||
                   (funct3 == F3_BLT) || (funct3 == F3_BGE);
        isBranch = 1'b1;
        op       = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a harmless ADD with no side effects.
  assign illegal    = !legal;
  assign aluControl = legal ? op : ALU_ADD;
  assign branch     = legal && isBranch;
  assign useImm     = legal && (opcode == OP_I);
  assign regWrite   = legal && !isBranch && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - D/E pipeline registers and M/W forwarding into the ALU
//
// Purpose: decode the D-stage instruction, register operands and control
//          across D/E with stall/flush, and forward M/W results onto SrcAE/SrcBE.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ValidD, InstrD, RD1D, RD2D       D-stage instruction and register reads
//   StallE, FlushE                   hold / bubble the E registers
//   RegWriteM, RdM, ALUResultM       M-stage forward source
//   RegWriteW, RdW, ResultW          W-stage forward source
//   SrcAE, SrcBE                     forwarded ALU operands
//   ALUControlE, funct3E, BranchE    ALU control
//   RegWriteE, RdE, ValidE, IllegalE E-stage status

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidD,
  input  logic [31:0]           InstrD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  output logic [XLEN-1:0]       SrcAE,
  output logic [XLEN-1:0]       SrcBE,
  output logic [3:0]            ALUControlE,
  output logic [2:0]            funct3E,
  output logic                  BranchE,
  output logic                  RegWriteE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  ValidE,
  output logic                  IllegalE
);

  logic [3:0]            decAluControl;
  logic                  decUseImm;
  logic                  decBranch;
  logic                  decRegWrite;
  logic                  decIllegal;
  logic [XLEN-1:0]       decImm;

  logic [REG_ADDR_W-1:0] rs1E;
  logic [REG_ADDR_W-1:0] rs2E;
  logic                  useImmE;
  logic [XLEN-1:0]       rd1E;
  logic [XLEN-1:0]       opBE;   // rs2 read data, or the immediate when useImmE

  alu_decoder #(.XLEN(XLEN)) uDecoder (
    .instr      (InstrD),
    .aluControl (decAluControl),
    .useImm     (decUseImm),
    .branch     (decBranch),
    .regWrite   (decRegWrite),
    .illegal    (decIllegal),
    .imm        (decImm)
  );

  // A bubble clears every E register, including the source indices, so a
  // bubble can never match a forward (x0 is never forwarded).
  always_ff @(posedge clk) begin
    if (rst || FlushE || (!StallE && !ValidD)) begin
      ValidE      <= 1'b0;
      ALUControlE <= ALU_ADD;
      funct3E     <= 3'b000;
      BranchE     <= 1'b0;
      RegWriteE   <= 1'b0;
      IllegalE    <= 1'b0;
      RdE         <= '0;
      rs1E        <= '0;
      rs2E        <= '0;
      useImmE     <= 1'b0;
      rd1E        <= '0;
      opBE        <= '0;
    end else if (!StallE) begin
      ValidE      <= 1'b1;
      ALUControlE <= decAluControl;
      funct3E     <= InstrD[14:12];
      BranchE     <= decBranch;
      RegWriteE   <= decRegWrite;
      IllegalE    <= decIllegal;
      RdE         <= InstrD[11:7];
      rs1E        <= InstrD[19:15];
      rs2E        <= InstrD[24:20];
      useImmE     <= decUseImm;
      rd1E        <= RD1D;
      opBE        <= decUseImm ? decImm : RD2D;
    end
  end

  // M beats W when both match the same source.
  always_comb begin
    SrcAE = rd1E;
    if (RegWriteM && (RdM != '0) && (RdM == rs1E))
      SrcAE = ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == rs1E))
      SrcAE = ResultW;
  end

  always_comb begin
    SrcBE = opBE;
    if (!useImmE) begin
      if (RegWriteM && (RdM != '0) && (RdM == rs2E))
        SrcBE = ALUResultM;
      else if (RegWriteW && (RdW != '0) && (RdW == rs2E))
        SrcBE = ResultW;
    end
  end

endmodule
